// File: rtl/multiexp_pkg.sv
// ---------------------------------------------------------------------------
// multiexp_pkg
// Definitions shared across the multiexp memory-side blocks.
//   BURSTCOUNT_W : width of the Avalon-MM burstcount field (1..64 beats)
//   init_state_e : sequencing states of the memory initialiser
// ---------------------------------------------------------------------------
package multiexp_pkg;

   localparam int BURSTCOUNT_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } init_state_e;

endpackage : multiexp_pkg

// File: rtl/mem_init.sv
// ---------------------------------------------------------------------------
// mem_init
// Clears a memory region by streaming FILL into NUM_WORDS words through an
// Avalon-MM burst write master, then reports completion so the reset
// controller can release the controller-side reset.
//
// Ports
//   bus_clk          in   clock (rising edge)
//   cpu_resetn       in   asynchronous active-low reset
//   mpfe_reset_n     in   memory port ready (synchronous level); high runs
//                         the clear sequence, low abandons it
//   avm_address      out  word address of the first beat of the burst
//   avm_write        out  write request
//   avm_writedata    out  constant FILL
//   avm_byteenable   out  constant all ones
//   avm_burstcount   out  constant BURST
//   avm_waitrequest  in   slave stall
//   init_done        out  whole region has been written
//   init_busy        out  clear sequence in progress
// ---------------------------------------------------------------------------
module mem_init
   import multiexp_pkg::*;
#(
   parameter int                ADDR_W    = 26,
   parameter int                DATA_W    = 256,
   parameter int                BURST     = 8,
   parameter int                NUM_WORDS = 2**26,
   parameter logic [DATA_W-1:0] FILL      = '0
) (
   input  logic                    bus_clk,
   input  logic                    cpu_resetn,
   input  logic                    mpfe_reset_n,
   output logic [ADDR_W-1:0]       avm_address,
   output logic                    avm_write,
   output logic [DATA_W-1:0]       avm_writedata,
   output logic [DATA_W/8-1:0]     avm_byteenable,
   output logic [BURSTCOUNT_W-1:0] avm_burstcount,
   input  logic                    avm_waitrequest,
   output logic                    init_done,
   output logic                    init_busy
);

   // One extra address bit so the post-increment past the final burst of a
   // full 2**ADDR_W region does not alias back to zero.
   localparam int                    CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0]      LAST_ADDR = CNT_W'(NUM_WORDS - BURST);
   localparam logic [CNT_W-1:0]      BURST_INC = CNT_W'(BURST);
   localparam logic [BURSTCOUNT_W-1:0] LAST_BEAT = BURSTCOUNT_W'(BURST - 1);

   init_state_e             state_q, state_d;
   logic [CNT_W-1:0]        addr_q, addr_d;
   logic [BURSTCOUNT_W-1:0] beat_q, beat_d;
   logic                    write_q, write_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;
   logic                    accept;

   // write_q mirrors "state is WRITE", so this is the accepted-beat strobe.
   assign accept = write_q && !avm_waitrequest;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      beat_d  = beat_q;

      case (state_q)
         ST_IDLE: begin
            if (mpfe_reset_n) begin
               addr_d  = '0;
               beat_d  = '0;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (accept) begin
               if (beat_q == LAST_BEAT) begin
                  beat_d = '0;
                  addr_d = addr_q + BURST_INC;
                  // Completion keys off the burst-start address, never off
                  // an address-counter overflow.
                  if (addr_q == LAST_ADDR) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Losing the memory port abandons everything; progress is not kept.
      if (!mpfe_reset_n) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         beat_d  = '0;
      end

      // Outputs are registered copies of the next-state decode.
      write_d = (state_d == ST_WRITE);
      busy_d  = (state_d == ST_WRITE);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge bus_clk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         beat_q  <= '0;
         write_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         write_q <= write_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign avm_address    = addr_q[ADDR_W-1:0];
   assign avm_write      = write_q;
   assign avm_writedata  = FILL;
   assign avm_byteenable = '1;
   assign avm_burstcount = BURSTCOUNT_W'(BURST);
   assign init_done      = done_q;
   assign init_busy      = busy_q;

endmodule : mem_init
